lighthouse_ootx_encoder: RTL and testbench

//  Transmit end of the lighthouse OOTX link: emits a base-station OOTX frame one bit per

---
 rtl/lighthouse_ootx_encoder_pkg.sv | 46 ++++
 rtl/lighthouse_ootx_encoder_if.sv | 20 ++
 rtl/lighthouse_ootx_encoder_crc.sv | 54 +++++
 rtl/lighthouse_ootx_encoder.sv | 220 ++++++++++++++++++++++
 tb/tb_lighthouse_ootx_encoder.sv | 379 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lighthouse_ootx_encoder_pkg.sv
// Lighthouse OOTX encoder shared definitions.
// Constants, register map, FSM encoding, byte helper.
package lighthouse_ootx_encoder_pkg;

  localparam int          OOTX_PREAMBLE_LEN = 17;
  localparam logic [31:0] OOTX_CRC_POLY     = 32'hEDB88320;
  localparam logic [31:0] OOTX_CRC_INIT     = 32'hFFFFFFFF;
  localparam logic [31:0] OOTX_CRC_XOROUT   = 32'hFFFFFFFF;

  localparam int          PL_WORDS = 9;

  localparam logic [5:0]  ADDR_CTRL     = 6'd0;
  localparam logic [5:0]  ADDR_STATUS   = 6'd1;
  localparam logic [5:0]  ADDR_PL_FIRST = 6'd2;
  localparam logic [5:0]  ADDR_PL_LAST  = 6'd10;
  localparam logic [5:0]  ADDR_CRC      = 6'd11;
  localparam logic [31:0] RD_UNMAPPED   = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CRC,
    ST_PREAMBLE,
    ST_SYNC,
    ST_WORD,
    ST_DONE
  } ootx_state_t;

  function automatic int ootx_frame_words(input int n);
    return 1 + (n + 1) / 2 + 2;
  endfunction

  // Bytes at or beyond len read as the zero pad byte.
  function automatic logic [7:0] ootx_byte(
    input logic [31:0] words [PL_WORDS],
    input logic [5:0]  idx,
    input int          len
  );
    logic [7:0] v;
    v = 8'h00;
    if (int'(idx) < len)
      v = words[idx[5:2]][{idx[1:0], 3'b000} +: 8];
    return v;
  endfunction

endpackage

// File: rtl/lighthouse_ootx_encoder_if.sv
// Avalon-MM host port of the OOTX encoder.
// Master drives the bus, slave answers.
interface lighthouse_ootx_encoder_if;
  logic [5:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;
  logic        waitrequest;

  modport master (
    output address, write, writedata, read,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, write, writedata, read,
    output readdata, waitrequest
  );
endinterface

// File: rtl/lighthouse_ootx_encoder_crc.sv
// Bit-serial reflected CRC32, one byte per 8 cycles.
// i_init restarts the running value.
module ootx_crc32_serial
  import lighthouse_ootx_encoder_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_init,
  input  logic        i_start,
  input  logic [7:0]  i_byte,
  output logic        o_done,
  output logic [31:0] o_crc
);

  logic [31:0] r_crc;
  logic [7:0]  r_data;
  logic [2:0]  r_cnt;
  logic        r_busy;
  logic        r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc  <= OOTX_CRC_INIT;
      r_data <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_init) begin
        r_crc  <= OOTX_CRC_INIT;
        r_cnt  <= '0;
        r_busy <= 1'b0;
      end else if (r_busy) begin
        r_crc  <= (r_crc >> 1) ^
                  ((r_crc[0] ^ r_data[0]) ? OOTX_CRC_POLY : 32'h0);
        r_data <= r_data >> 1;
        r_cnt  <= r_cnt + 3'd1;
        if (r_cnt == 3'd7) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end else if (i_start) begin
        r_data <= i_byte;
        r_cnt  <= '0;
        r_busy <= 1'b1;
      end
    end
  end

  assign o_done = r_done;
  assign o_crc  = r_crc ^ OOTX_CRC_XOROUT;

endmodule

// File: rtl/lighthouse_ootx_encoder.sv
// OOTX frame transmitter: Avalon regfile, double buffer,
// CRC pass, then one frame bit per bit_req.
module lighthouse_ootx_encoder
  import lighthouse_ootx_encoder_pkg::*;
#(
  parameter int PAYLOAD_BYTES = 33
) (
  input  logic clock,
  input  logic reset_n,
  lighthouse_ootx_encoder_if.slave bus,
  input  logic bit_req,
  output logic ootx_bit,
  output logic bit_valid,
  output logic frame_done
);

  localparam int DATA_WORDS = (PAYLOAD_BYTES + 1) / 2;
  localparam int NWORDS     = ootx_frame_words(PAYLOAD_BYTES);

  localparam logic [15:0] LEN16       = 16'(PAYLOAD_BYTES);
  localparam logic [5:0]  LAST_BYTE   = 6'(PAYLOAD_BYTES - 1);
  localparam logic [4:0]  LAST_DATA_W = 5'(DATA_WORDS);
  localparam logic [4:0]  W_CRC0      = 5'(DATA_WORDS + 1);
  localparam logic [4:0]  W_END       = 5'(NWORDS);
  localparam logic [4:0]  PRE_LAST    = 5'(OOTX_PREAMBLE_LEN - 1);

  ootx_state_t r_state;
  logic        r_enable;
  logic [15:0] r_frame_cnt;
  logic [31:0] r_stage  [PL_WORDS];
  logic [31:0] r_shadow [PL_WORDS];
  logic [31:0] r_crc_last;
  logic [5:0]  r_byte_idx;
  logic        r_crc_go;
  logic [4:0]  r_pre_cnt;
  logic [4:0]  r_word_idx;
  logic [3:0]  r_bit_idx;
  logic [15:0] r_shift;
  logic        r_ootx_bit;
  logic        r_bit_valid;
  logic        r_frame_done;

  logic        w_is_pl;
  logic [3:0]  w_pl_idx;
  logic        w_wait;
  logic        w_wr_ctrl;
  logic        w_busy;
  logic        w_crc_busy;
  logic [31:0] w_rdata;
  logic        w_crc_init;
  logic        w_crc_start;
  logic        w_crc_done;
  logic [31:0] w_crc;
  logic [7:0]  w_crc_byte;
  logic [5:0]  w_hi_idx;
  logic [5:0]  w_lo_idx;
  logic [7:0]  w_hi_byte;
  logic [7:0]  w_lo_byte;
  logic        w_is_len;
  logic        w_is_dat;
  logic        w_is_c0;
  logic [15:0] w_word;

  assign w_is_pl    = (bus.address >= ADDR_PL_FIRST) &&
                      (bus.address <= ADDR_PL_LAST);
  assign w_pl_idx   = bus.address[3:0] - 4'd2;
  // CTRL is held off for the single LOAD cycle
  assign w_wait     = bus.write && (bus.address == ADDR_CTRL) &&
                      (r_state == ST_LOAD);
  assign w_wr_ctrl  = bus.write && (bus.address == ADDR_CTRL) && !w_wait;
  assign w_busy     = (r_state != ST_IDLE);
  assign w_crc_busy = (r_state == ST_CRC);

  always_comb begin
    w_rdata = RD_UNMAPPED;
    unique case (1'b1)
      (bus.address == ADDR_CTRL):   w_rdata = {31'b0, r_enable};
      (bus.address == ADDR_STATUS): w_rdata = {r_frame_cnt, 14'b0,
                                               w_crc_busy, w_busy};
      w_is_pl:                      w_rdata = r_stage[w_pl_idx];
      (bus.address == ADDR_CRC):    w_rdata = r_crc_last;
      default: ;
    endcase
  end

  assign bus.readdata    = w_rdata;
  assign bus.waitrequest = w_wait;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_enable <= 1'b0;
      for (int i = 0; i < PL_WORDS; i++) r_stage[i] <= '0;
    end else begin
      if (w_wr_ctrl) r_enable <= bus.writedata[0];
      if (bus.write && w_is_pl) r_stage[w_pl_idx] <= bus.writedata;
    end
  end

  assign w_crc_init  = (r_state == ST_LOAD);
  assign w_crc_start = (r_state == ST_CRC) && r_crc_go;
  assign w_crc_byte  = ootx_byte(r_shadow, r_byte_idx, PAYLOAD_BYTES);

  ootx_crc32_serial u_crc (
    .clk     (clock),
    .rst_n   (reset_n),
    .i_init  (w_crc_init),
    .i_start (w_crc_start),
    .i_byte  (w_crc_byte),
    .o_done  (w_crc_done),
    .o_crc   (w_crc)
  );

  assign w_hi_idx  = {r_word_idx, 1'b0} - 6'd2;
  assign w_lo_idx  = {r_word_idx, 1'b0} - 6'd1;
  assign w_hi_byte = ootx_byte(r_shadow, w_hi_idx, PAYLOAD_BYTES);
  assign w_lo_byte = ootx_byte(r_shadow, w_lo_idx, PAYLOAD_BYTES);
  assign w_is_len  = (r_word_idx == 5'd0);
  assign w_is_dat  = !w_is_len && (r_word_idx <= LAST_DATA_W);
  assign w_is_c0   = (r_word_idx == W_CRC0);

  always_comb begin
    w_word = {r_crc_last[23:16], r_crc_last[31:24]};
    unique case (1'b1)
      w_is_len: w_word = {LEN16[7:0], LEN16[15:8]};
      w_is_dat: w_word = {w_hi_byte, w_lo_byte};
      w_is_c0:  w_word = {r_crc_last[7:0], r_crc_last[15:8]};
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_frame_cnt  <= '0;
      r_crc_last   <= '0;
      r_byte_idx   <= '0;
      r_crc_go     <= 1'b0;
      r_pre_cnt    <= '0;
      r_word_idx   <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_ootx_bit   <= 1'b0;
      r_bit_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      for (int i = 0; i < PL_WORDS; i++) r_shadow[i] <= '0;
    end else begin
      r_bit_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (r_enable) r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          r_shadow   <= r_stage;
          r_byte_idx <= '0;
          r_crc_go   <= 1'b1;
          r_pre_cnt  <= '0;
          r_word_idx <= '0;
          r_state    <= ST_CRC;
        end
        ST_CRC: begin
          r_crc_go <= 1'b0;
          if (w_crc_done) begin
            if (r_byte_idx == LAST_BYTE) begin
              r_crc_last <= w_crc;
              r_state    <= ST_PREAMBLE;
            end else begin
              r_byte_idx <= r_byte_idx + 6'd1;
              r_crc_go   <= 1'b1;
            end
          end
        end
        ST_PREAMBLE: begin
          if (bit_req) begin
            r_ootx_bit  <= 1'b0;
            r_bit_valid <= 1'b1;
            r_pre_cnt   <= r_pre_cnt + 5'd1;
            if (r_pre_cnt == PRE_LAST) r_state <= ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (bit_req) begin
            r_ootx_bit  <= 1'b1;
            r_bit_valid <= 1'b1;
            if (r_word_idx == W_END) begin
              r_state <= ST_DONE;
            end else begin
              r_shift   <= w_word;
              r_bit_idx <= '0;
              r_state   <= ST_WORD;
            end
          end
        end
        ST_WORD: begin
          if (bit_req) begin
            r_ootx_bit  <= r_shift[15];
            r_bit_valid <= 1'b1;
            r_shift     <= {r_shift[14:0], 1'b0};
            r_bit_idx   <= r_bit_idx + 4'd1;
            if (r_bit_idx == 4'd15) begin
              r_word_idx <= r_word_idx + 5'd1;
              r_state    <= ST_SYNC;
            end
          end
        end
        ST_DONE: begin
          r_frame_done <= 1'b1;
          r_frame_cnt  <= r_frame_cnt + 16'd1;
          r_state      <= r_enable ? ST_LOAD : ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ootx_bit   = r_ootx_bit;
  assign bit_valid  = r_bit_valid;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_lighthouse_ootx_encoder.sv
// Directed bench for the OOTX encoder: register table,
// full frames against a software frame/CRC model, corner sequences.
module tb_lighthouse_ootx_encoder;

  localparam int PB = 33;
  localparam int NW = 1 + (PB + 1) / 2 + 2;
  localparam int FB = 18 + 17 * NW;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] exp;
  } rvec_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic bit_req = 1'b0;
  logic ootx_bit;
  logic bit_valid;
  logic frame_done;

  int checks = 0;
  int errors = 0;
  int n_valid = 0;
  int n_done = 0;
  logic req_q = 1'b0;

  logic [7:0]  pl [36];
  bit          got  [FB];
  bit          expb [FB];
  logic [31:0] exp_crc;

  rvec_t rv_rst [7];
  rvec_t rv_pl  [12];

  always #5 clock = ~clock;

  lighthouse_ootx_encoder_if bus ();

  lighthouse_ootx_encoder #(.PAYLOAD_BYTES(PB)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .bus        (bus),
    .bit_req    (bit_req),
    .ootx_bit   (ootx_bit),
    .bit_valid  (bit_valid),
    .frame_done (frame_done)
  );

  always @(posedge clock) req_q <= bit_req;

  always @(negedge clock) begin
    if (frame_done) n_done++;
    if (bit_valid) begin
      n_valid++;
      checks++;
      if (!req_q) begin
        errors++;
        $display("FAIL bit_valid_without_req: got 1 expected 0 at %0t", $time);
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] g,
                     input logic [31:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, g, e);
    end
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] d);
    @(negedge clock);
    bus.address = a;
    #1 d = bus.readdata;
  endtask

  task automatic av_write(input logic [5:0] a, input logic [31:0] d);
    int n;
    @(negedge clock);
    bus.address = a;
    bus.writedata = d;
    bus.write = 1'b1;
    #1;
    n = 0;
    while (bus.waitrequest && n < 8) begin
      @(negedge clock);
      #1 n++;
    end
    @(posedge clock);
    #1 bus.write = 1'b0;
  endtask

  task automatic get_bit(input int gap, output bit b, output bit ok);
    ok = 1'b0;
    b = 1'b0;
    for (int a = 0; a < 400 && !ok; a++) begin
      repeat (gap) @(negedge clock);
      bit_req = 1'b1;
      @(negedge clock);
      bit_req = 1'b0;
      if (bit_valid) begin
        ok = 1'b1;
        b = ootx_bit;
      end
    end
  endtask

  task automatic capture(input int gap, input int wr_at,
                         input logic [5:0] wa, input logic [31:0] wd,
                         input int nbits, output int n);
    bit b;
    bit ok;
    n = 0;
    for (int i = 0; i < nbits; i++) begin
      if (i == wr_at) av_write(wa, wd);
      get_bit(gap, b, ok);
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL bit_timeout: got no bit_valid expected bit %0d", i);
        break;
      end
      got[i] = b;
      n++;
    end
  endtask

  function automatic logic [31:0] crc32(input logic [7:0] d [36],
                                        input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, d[i]};
      for (int j = 0; j < 8; j++)
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic build_exp();
    logic [7:0]  pb [36];
    logic [15:0] w  [NW];
    int nd;
    int p;
    nd = (PB + 1) / 2;
    for (int i = 0; i < 36; i++) pb[i] = (i < PB) ? pl[i] : 8'h00;
    exp_crc = crc32(pl, PB);
    w[0] = {8'(PB), 8'(PB >> 8)};
    for (int k = 1; k <= nd; k++) w[k] = {pb[2*k-2], pb[2*k-1]};
    w[nd+1] = {exp_crc[7:0], exp_crc[15:8]};
    w[nd+2] = {exp_crc[23:16], exp_crc[31:24]};
    p = 0;
    for (int i = 0; i < 17; i++) expb[p++] = 1'b0;
    expb[p++] = 1'b1;
    for (int k = 0; k < NW; k++) begin
      for (int j = 15; j >= 0; j--) expb[p++] = w[k][j];
      expb[p++] = 1'b1;
    end
  endtask

  task automatic cmp_bits(input string nm, input int n);
    int mism;
    int first;
    mism = 0;
    first = -1;
    for (int i = 0; i < n; i++)
      if (got[i] != expb[i]) begin
        if (first < 0) first = i;
        mism++;
      end
    if (mism != 0)
      $display("first differing bit of %s at index %0d", nm, first);
    chk(nm, mism, 0);
  endtask

  task automatic chk_frame_shape(input string nm);
    logic [15:0] w0;
    int bad;
    bad = 0;
    for (int i = 0; i < 17; i++) if (got[i]) bad++;
    if (!got[17]) bad++;
    for (int k = 0; k < NW; k++) if (!got[34 + 17*k]) bad++;
    chk({nm, "_preamble_sync"}, bad, 0);
    for (int j = 0; j < 16; j++) w0[15-j] = got[18 + j];
    chk({nm, "_word0"}, {16'h0, w0}, 32'h0000_2100);
  endtask

  initial begin
    logic [31:0] d;
    int n;
    int snap;
    int saw_busy;
    int viol;
    int found;
    bit first_b;
    bit b;
    bit ok;
    bit pre_rst_bit;

    rv_rst[0] = '{6'd0,  32'h0000_0000};
    rv_rst[1] = '{6'd1,  32'h0000_0000};
    rv_rst[2] = '{6'd2,  32'h0000_0000};
    rv_rst[3] = '{6'd10, 32'h0000_0000};
    rv_rst[4] = '{6'd11, 32'h0000_0000};
    rv_rst[5] = '{6'd12, 32'hDEAD_BEEF};
    rv_rst[6] = '{6'd63, 32'hDEAD_BEEF};

    rv_pl[0]  = '{6'd2,  32'h0302_0100};
    rv_pl[1]  = '{6'd3,  32'h0706_0504};
    rv_pl[2]  = '{6'd4,  32'h0B0A_0908};
    rv_pl[3]  = '{6'd5,  32'h0F0E_0D0C};
    rv_pl[4]  = '{6'd6,  32'h1312_1110};
    rv_pl[5]  = '{6'd7,  32'h1716_1514};
    rv_pl[6]  = '{6'd8,  32'h1B1A_1918};
    rv_pl[7]  = '{6'd9,  32'h1F1E_1D1C};
    rv_pl[8]  = '{6'd10, 32'h0000_0020};
    rv_pl[9]  = '{6'd0,  32'h0000_0000};
    rv_pl[10] = '{6'd1,  32'h0000_0000};
    rv_pl[11] = '{6'd13, 32'hDEAD_BEEF};

    for (int i = 0; i < 36; i++) pl[i] = (i < PB) ? 8'(i) : 8'h00;

    bus.address = '0;
    bus.write = 1'b0;
    bus.writedata = '0;
    bus.read = 1'b0;

    repeat (3) @(negedge clock);
    #1;
    chk("rst_ootx_bit", {31'b0, ootx_bit}, 0);
    chk("rst_bit_valid", {31'b0, bit_valid}, 0);
    chk("rst_frame_done", {31'b0, frame_done}, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      rd(rv_rst[i].addr, d);
      chk($sformatf("rst_reg%0d", rv_rst[i].addr), d, rv_rst[i].exp);
    end

    bus.read = 1'b1;
    for (int i = 0; i < 9; i++) av_write(rv_pl[i].addr, rv_pl[i].exp);
    for (int i = 0; i < 12; i++) begin
      rd(rv_pl[i].addr, d);
      chk($sformatf("pl_reg%0d", rv_pl[i].addr), d, rv_pl[i].exp);
    end

    // frame 1, every 20 clocks; payload word 2 rewritten at bit 100
    build_exp();
    av_write(6'd0, 32'h1);
    capture(19, 100, 6'd2, 32'hA5A5_5A5A, FB, n);
    chk("f1_len", n, FB);
    cmp_bits("f1_bits", n);
    chk_frame_shape("f1");

    @(negedge clock);
    chk("f1_frame_done", {31'b0, frame_done}, 1);
    bus.address = 6'd0;
    bus.writedata = 32'h1;
    bus.write = 1'b1;
    #1 chk("wait_in_load", {31'b0, bus.waitrequest}, 1);
    @(negedge clock);
    #1 chk("wait_after_load", {31'b0, bus.waitrequest}, 0);
    @(posedge clock);
    #1 bus.write = 1'b0;

    rd(6'd11, d);
    chk("f1_crc_reg", d, exp_crc);
    rd(6'd1, d);
    chk("f1_status", d, 32'h0001_0003);
    rd(6'd2, d);
    chk("stage_rewrite", d, 32'hA5A5_5A5A);

    // frame 2 carries the rewritten payload
    pl[0] = 8'h5A;
    pl[1] = 8'h5A;
    pl[2] = 8'hA5;
    pl[3] = 8'hA5;
    build_exp();
    capture(3, -1, 6'd0, 32'h0, FB, n);
    chk("f2_len", n, FB);
    cmp_bits("f2_bits", n);
    chk_frame_shape("f2");
    rd(6'd11, d);
    chk("f2_crc_reg", d, exp_crc);
    rd(6'd1, d);
    chk("f2_frame_count", {16'h0, d[31:16]}, 2);

    // frame 3: enable cleared at bit 200
    snap = n_done;
    capture(3, 200, 6'd0, 32'h0, FB, n);
    chk("f3_len", n, FB);
    cmp_bits("f3_bits", n);
    repeat (4) @(negedge clock);
    chk("f3_done_once", n_done - snap, 1);
    rd(6'd1, d);
    chk("f3_status_idle", d, 32'h0003_0000);
    snap = n_valid;
    for (int i = 0; i < 5; i++) begin
      repeat (2) @(negedge clock);
      bit_req = 1'b1;
      @(negedge clock);
      bit_req = 1'b0;
    end
    repeat (2) @(negedge clock);
    chk("idle_no_bits", n_valid - snap, 0);

    // bit_req held through LOAD/CRC
    bit_req = 1'b1;
    av_write(6'd0, 32'h1);
    saw_busy = 0;
    viol = 0;
    found = 0;
    first_b = 1'b1;
    for (int i = 0; i < 3000 && found == 0; i++) begin
      @(negedge clock);
      bus.address = 6'd1;
      #1;
      if (bus.readdata[1]) saw_busy = 1;
      if (bit_valid && bus.readdata[1]) viol++;
      if (bit_valid && !bus.readdata[1]) begin
        found = 1;
        first_b = ootx_bit;
      end
    end
    bit_req = 1'b0;
    chk("hold_saw_crc_busy", saw_busy, 1);
    chk("hold_no_bit_in_crc", viol, 0);
    chk("hold_first_bit_found", found, 1);
    chk("hold_first_bit", {31'b0, first_b}, 0);

    // continue to bit 50 then reset mid-frame
    got[0] = first_b;
    n = 1;
    for (int i = 1; i < 50; i++) begin
      get_bit(3, b, ok);
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL f4_bit_timeout: got no bit_valid expected bit %0d", i);
        break;
      end
      got[i] = b;
      n++;
    end
    cmp_bits("f4_first50", n);
    pre_rst_bit = ootx_bit;
    chk("f4_bit49", {31'b0, pre_rst_bit}, {31'b0, expb[49]});

    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ootx_bit", {31'b0, ootx_bit}, 0);
    chk("mid_rst_bit_valid", {31'b0, bit_valid}, 0);
    chk("mid_rst_frame_done", {31'b0, frame_done}, 0);
    rd(6'd0, d);
    chk("mid_rst_ctrl", d, 0);
    rd(6'd2, d);
    chk("mid_rst_reg2", d, 0);
    rd(6'd1, d);
    chk("mid_rst_status", d, 0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    rd(6'd1, d);
    chk("post_rst_status", d, 0);
    chk("post_rst_ootx_bit", {31'b0, ootx_bit}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
